fix_msg_serializer: RTL
=======================

# fix_msg_serializer

Transmit-side counterpart of the FIX tag/value parser. It accepts one tag/value field per handshake, in the same right-aligned packed format the parser writes into its tag and value FIFOs. It serializes each field onto an 8-bit byte stream as `tag '=' value SOH` and, when enabled, appends the FIX `10=nnn` checksum trailer. It sits between the outbound tag/value FIFOs and the line-side byte interface.

## Interface
- `VAL_BYTES`, default 32: maximum value length in bytes; the value bus is 8*VAL_BYTES bits.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `field_valid_i` input 1: a field is presented on the tag/value inputs.
- `field_ready_o` output 1: serializer can accept a field.
- `tag_i` input 32: tag in ASCII, right-aligned; last character in [7:0].
- `tag_len_i` input 3: tag length in characters, 1..4.
- `value_i` input 8*VAL_BYTES: value in ASCII, right-aligned; last character in [7:0].
- `value_len_i` input 6: value length in characters, 0..VAL_BYTES.
- `last_field_i` input 1: this field is the last body field of the message.
- `data_o` output 8: serialized byte.
- `data_valid_o` output 1: `data_o` is valid.
- `data_ready_i` input 1: sink accepts `data_o`.
- `start_message_o` output 1: qualifies the first byte of a message.
- `end_message_o` output 1: qualifies the final byte of a message.

## Operation
- States:
  - IDLE: `field_ready_o`=1. On valid&&ready, capture tag, value, lengths and last flag. Set tag index to tag_len-1 and go to TAG.
  - TAG: emit tag bytes from the highest used byte down to byte 0, then go to EQ.
  - EQ: emit 8'h3D. Go to VAL, or to SOH if value_len=0.
  - VAL: emit value bytes from index value_len-1 down to 0, then go to SOH.
  - SOH: emit 8'h01.
    - If last is clear, go to IDLE.
    - If last is set with FIX_CHECKSUM_EN defined, go to CK_TAG.
    - If last is set without the macro, go to IDLE.
  - CK_TAG: emit "1", "0", "=" (8'h31, 8'h30, 8'h3D), then go to CK_DIG.
  - CK_DIG: emit hundreds, tens and units digits of the checksum as ASCII (8'h30+d), then go to CK_SOH.
  - CK_SOH: emit 8'h01, then go to IDLE.
- State advances only on a byte handshake (`data_valid_o && data_ready_i`). IDLE is the exception: it advances on the field handshake.
- Input clamping:
  - `tag_len_i`=0 is treated as 1.
  - `tag_len_i` >4 is treated as 4.
  - `value_len_i` >VAL_BYTES is treated as VAL_BYTES.
- Checksum:
  - 8-bit accumulator, wraps modulo 256.
  - Adds every byte emitted from TAG through SOH, including '=' and SOH.
  - Cleared when the first field of a message is accepted.
  - Trailer bytes are not summed.
- Message framing: the first field accepted after reset, or after a message ends, opens a new message.
- `start_message_o` is asserted with the first tag byte of a message.
- `end_message_o` is asserted with the CK_SOH byte when the macro is defined; otherwise with the SOH byte of the last field.

## Timing
- Reset values:
  - State IDLE, accumulator 0.
  - `field_ready_o`=0 in the reset cycle, 1 on the first cycle after reset is released.
  - `data_valid_o`=0, `data_o`=8'h00, `start_message_o`=0, `end_message_o`=0.
- All outputs are registered.
- Latency: field accepted at edge N gives its first byte valid in cycle N+1.
- Throughput: one byte per cycle while `data_ready_i`=1.
- Field overhead: tag_len + value_len + 2 cycles per field, plus 7 cycles for the trailer.
- `field_ready_o` is 1 only in IDLE. The cycle after the final byte handshake, the block is back in IDLE with `field_ready_o`=1 (no back-to-back field acceptance).
- Backpressure: while `data_ready_i`=0, `data_o`, `data_valid_o` and both flags hold stable. `data_valid_o` never drops before its handshake.
- Reset mid-message: the partial message is abandoned with no trailer, and state returns to IDLE on the next edge.

## Configuration
- Macro: `FIX_CHECKSUM_EN`.
- With the macro: the accumulator, the CK_* states and the checksum digit conversion are compiled in, and the trailer is appended after the last field.
- Without the macro: no accumulator and no CK_* states. The upstream block supplies tag 10 as an ordinary field marked last.

## Structure
- Shared package `fix_pkg`:
  - ASCII constants: SOH 8'h01, EQ 8'h3D, DIGIT0 8'h30, CHECKSUM_TAG 16'h3130, BEGIN_TAG 8'h38.
  - Serializer state enum.
  - `VAL_BYTES` default.
- Sub-module `fix_checksum_ascii`: combinational 8-bit binary to three ASCII decimal digits. Instantiated only under `FIX_CHECKSUM_EN`.

## Test plan
- Tag "8" (len 1), value "A" (len 1), last=1, macro on, `data_ready_i` tied 1:
  - Stream is 38 3D 41 01 31 30 3D 31 38 33 01 (checksum 183).
  - start flag on byte 0, end flag on byte 10.
- Tag "8", value "FIX.4.2", last=1: checksum 543 mod 256 = 31, so trailer digits are 30 33 31 ("031"). Verifies wrap and leading zero.
- Tag "35" (tag_i=32'h00003335, len 2), value_len 0, last=0:
  - Stream is 33 35 3D 01 with no trailer.
  - `field_ready_o` returns high after the SOH.
- Backpressure: toggle `data_ready_i` randomly across a 3-field message. The byte sequence must be identical to the unstalled run, and outputs must be stable during stalls.
- Macro off, tag "10" value "183" last=1: stream is 31 30 3D 31 38 33 01 with `end_message_o` on the final 01 and no extra trailer.
- Assert `rst` during VAL:
  - Next cycle `data_valid_o`=0 and `field_ready_o`=0; `field_ready_o`=1 the cycle after reset is released.
  - A following single-field message has a checksum unaffected by the aborted bytes.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared definitions for the FIX transmit path.
//
// Contents:
//   - ASCII constants used on the wire (SOH, '=', digit base, checksum and
//     BeginString tags).
//   - ser_state_e: serializer FSM state encoding. It is exported on the
//     serializer's dbg_state port.
//   - VAL_BYTES_DEFAULT: default maximum value length in bytes.
package fix_pkg;

    localparam logic [7:0]  SOH           = 8'h01;
    localparam logic [7:0]  EQ            = 8'h3D;
    localparam logic [7:0]  DIGIT0        = 8'h30;
    localparam logic [15:0] CHECKSUM_TAG  = 16'h3130;  // "10"
    localparam logic [7:0]  BEGIN_TAG     = 8'h38;     // "8"

    localparam int VAL_BYTES_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG,
        ST_EQ,
        ST_VAL,
        ST_SOH,
        ST_CK_TAG,
        ST_CK_DIG,
        ST_CK_SOH
    } ser_state_e;

endpackage

// File: rtl/fix_msg_serializer_if.sv
// Field-in / byte-out bundle for fix_msg_serializer.
//
// Handshake semantics, identical on both sides: a transfer happens on a
// rising clk edge where valid and ready are both 1. The producer holds
// valid, and every signal it qualifies, stable until that transfer happens.
// The consumer may change ready freely.
//   field side: field_valid_i / field_ready_o qualify tag_i, tag_len_i,
//               value_i, value_len_i and last_field_i.
//   byte side:  data_valid_o / data_ready_i qualify data_o,
//               start_message_o and end_message_o.
//
// Modports:
//   slave  - the serializer.
//   master - the environment. It drives fields in and sinks bytes.
interface fix_msg_serializer_if
    import fix_pkg::*;
#(
    parameter int VAL_BYTES = VAL_BYTES_DEFAULT
);
    logic                   field_valid_i;
    logic                   field_ready_o;
    logic [31:0]            tag_i;
    logic [2:0]             tag_len_i;
    logic [8*VAL_BYTES-1:0] value_i;
    logic [5:0]             value_len_i;
    logic                   last_field_i;
    logic [7:0]             data_o;
    logic                   data_valid_o;
    logic                   data_ready_i;
    logic                   start_message_o;
    logic                   end_message_o;

    modport slave (
        input  field_valid_i, tag_i, tag_len_i, value_i, value_len_i,
               last_field_i, data_ready_i,
        output field_ready_o, data_o, data_valid_o, start_message_o,
               end_message_o
    );

    modport master (
        output field_valid_i, tag_i, tag_len_i, value_i, value_len_i,
               last_field_i, data_ready_i,
        input  field_ready_o, data_o, data_valid_o, start_message_o,
               end_message_o
    );

endinterface

// File: rtl/fix_checksum_ascii.sv
// Converts an 8-bit checksum into three ASCII decimal digits, with leading
// zeros kept ("031", not "31"). The module is purely combinational.
//
// Ports:
//   bin      in  8  binary value, 0..255
//   hundreds out 8  ASCII hundreds digit
//   tens     out 8  ASCII tens digit
//   units    out 8  ASCII units digit
module fix_checksum_ascii
    import fix_pkg::*;
(
    input  logic [7:0] bin,
    output logic [7:0] hundreds,
    output logic [7:0] tens,
    output logic [7:0] units
);

    logic [7:0] rem100;

    assign rem100   = bin % 8'd100;
    assign hundreds = DIGIT0 + (bin / 8'd100);
    assign tens     = DIGIT0 + (rem100 / 8'd10);
    assign units    = DIGIT0 + (rem100 % 8'd10);

endmodule

// File: rtl/fix_msg_serializer.sv
// FIX tag/value serializer (transmit side).
//
// The block takes one right-aligned tag/value field per field handshake. It
// emits the field as `tag '=' value SOH` on an 8-bit stream, one byte per
// byte handshake. All outputs are registered.
//
// Build option:
//   FIX_CHECKSUM_EN - when defined, the block keeps a mod-256 sum of every
//   body byte of a message. After the SOH of the field marked last, it
//   appends the trailer "10=nnn" SOH. When undefined, no trailer is
//   generated, and upstream sends tag 10 as an ordinary last field.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   bus        slave modport of fix_msg_serializer_if; carries field input
//              and byte output
//   dbg_state  out  current FSM state
module fix_msg_serializer
    import fix_pkg::*;
#(
    parameter int VAL_BYTES = VAL_BYTES_DEFAULT
)(
    input  logic                 clk,
    input  logic                 rst,
    fix_msg_serializer_if.slave  bus,
    output ser_state_e           dbg_state
);

`ifdef FIX_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    localparam logic [5:0] VAL_MAX = 6'(VAL_BYTES);

    ser_state_e             state;
    logic [31:0]            tag_r;
    logic [8*VAL_BYTES-1:0] val_r;
    logic [1:0]             tag_idx;
    logic [5:0]             val_idx;
    logic [5:0]             val_len_r;
    logic                   last_r;
    logic                   msg_open;   // a message has started and not yet ended

    logic [7:0] data_q;
    logic       valid_q;
    logic       ready_q;
    logic       start_q;
    logic       end_q;

    logic       field_hs;
    logic       byte_hs;
    logic [2:0] tag_len_c;
    logic [1:0] tag_top_c;
    logic [5:0] val_len_c;
    logic [1:0] tag_idx_m1;
    logic [5:0] val_idx_m1;
    logic [5:0] val_len_m1;
    logic [7:0] first_tag_byte;
    logic [7:0] next_tag_byte;
    logic [7:0] first_val_byte;
    logic [7:0] next_val_byte;

    assign field_hs = bus.field_valid_i && ready_q;
    assign byte_hs  = valid_q && bus.data_ready_i;

    // Clamp incoming lengths into the legal range before they are used.
    always_comb begin
        tag_len_c = bus.tag_len_i;
        if (bus.tag_len_i == 3'd0) begin
            tag_len_c = 3'd1;
        end else if (bus.tag_len_i > 3'd4) begin
            tag_len_c = 3'd4;
        end
        val_len_c = (bus.value_len_i > VAL_MAX) ? VAL_MAX : bus.value_len_i;
    end

    assign tag_top_c  = 2'(tag_len_c - 3'd1);
    assign tag_idx_m1 = tag_idx - 2'd1;
    assign val_idx_m1 = val_idx - 6'd1;
    assign val_len_m1 = val_len_r - 6'd1;

    // Fields are right-aligned, so character k from the end sits in byte k.
    // Bytes are emitted from the highest used byte down to byte 0.
    assign first_tag_byte = bus.tag_i[{tag_top_c, 3'b000} +: 8];
    assign next_tag_byte  = tag_r[{tag_idx_m1, 3'b000} +: 8];
    assign first_val_byte = val_r[{val_len_m1, 3'b000} +: 8];
    assign next_val_byte  = val_r[{val_idx_m1, 3'b000} +: 8];

`ifdef FIX_CHECKSUM_EN
    logic [7:0] csum;
    logic [1:0] ck_idx;
    logic [7:0] dig_h;
    logic [7:0] dig_t;
    logic [7:0] dig_u;

    fix_checksum_ascii u_ck_ascii (
        .bin      (csum),
        .hundreds (dig_h),
        .tens     (dig_t),
        .units    (dig_u)
    );

    // Sum of body bytes. It is cleared when a message opens. Trailer bytes
    // are not added. The sum is final once the last SOH has been accepted,
    // so it is stable for the whole trailer.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (field_hs && !msg_open) begin
            csum <= '0;
        end else if (byte_hs && (state inside {ST_TAG, ST_EQ, ST_VAL, ST_SOH})) begin
            csum <= csum + data_q;
        end
    end
`endif

    // Each transition loads the byte for the state being entered, so data_q
    // is always the byte for the current state. Without a byte handshake,
    // every output register holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            msg_open  <= 1'b0;
            tag_r     <= '0;
            val_r     <= '0;
            tag_idx   <= '0;
            val_idx   <= '0;
            val_len_r <= '0;
            last_r    <= 1'b0;
`ifdef FIX_CHECKSUM_EN
            ck_idx    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (field_hs) begin
                        tag_r     <= bus.tag_i;
                        val_r     <= bus.value_i;
                        val_len_r <= val_len_c;
                        last_r    <= bus.last_field_i;
                        tag_idx   <= tag_top_c;
                        data_q    <= first_tag_byte;
                        valid_q   <= 1'b1;
                        start_q   <= !msg_open;
                        end_q     <= 1'b0;
                        msg_open  <= 1'b1;
                        ready_q   <= 1'b0;
                        state     <= ST_TAG;
                    end else begin
                        ready_q   <= 1'b1;
                    end
                end

                ST_TAG: begin
                    if (byte_hs) begin
                        start_q <= 1'b0;
                        if (tag_idx == 2'd0) begin
                            data_q <= EQ;
                            state  <= ST_EQ;
                        end else begin
                            tag_idx <= tag_idx_m1;
                            data_q  <= next_tag_byte;
                        end
                    end
                end

                ST_EQ: begin
                    if (byte_hs) begin
                        if (val_len_r == 6'd0) begin
                            data_q <= SOH;
                            end_q  <= last_r && !CK_EN;
                            state  <= ST_SOH;
                        end else begin
                            val_idx <= val_len_m1;
                            data_q  <= first_val_byte;
                            state   <= ST_VAL;
                        end
                    end
                end

                ST_VAL: begin
                    if (byte_hs) begin
                        if (val_idx == 6'd0) begin
                            data_q <= SOH;
                            end_q  <= last_r && !CK_EN;
                            state  <= ST_SOH;
                        end else begin
                            val_idx <= val_idx_m1;
                            data_q  <= next_val_byte;
                        end
                    end
                end

                ST_SOH: begin
                    if (byte_hs) begin
`ifdef FIX_CHECKSUM_EN
                        if (last_r) begin
                            data_q <= CHECKSUM_TAG[15:8];
                            ck_idx <= 2'd0;
                            state  <= ST_CK_TAG;
                        end else begin
                            data_q  <= 8'h00;
                            valid_q <= 1'b0;
                            end_q   <= 1'b0;
                            ready_q <= 1'b1;
                            state   <= ST_IDLE;
                        end
`else
                        if (last_r) begin
                            msg_open <= 1'b0;
                        end
                        data_q  <= 8'h00;
                        valid_q <= 1'b0;
                        end_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
`endif
                    end
                end

`ifdef FIX_CHECKSUM_EN
                // ck_idx counts the trailer bytes already accepted in the
                // current CK_* state.
                ST_CK_TAG: begin
                    if (byte_hs) begin
                        if (ck_idx == 2'd0) begin
                            data_q <= CHECKSUM_TAG[7:0];
                            ck_idx <= 2'd1;
                        end else if (ck_idx == 2'd1) begin
                            data_q <= EQ;
                            ck_idx <= 2'd2;
                        end else begin
                            data_q <= dig_h;
                            ck_idx <= 2'd0;
                            state  <= ST_CK_DIG;
                        end
                    end
                end

                ST_CK_DIG: begin
                    if (byte_hs) begin
                        if (ck_idx == 2'd0) begin
                            data_q <= dig_t;
                            ck_idx <= 2'd1;
                        end else if (ck_idx == 2'd1) begin
                            data_q <= dig_u;
                            ck_idx <= 2'd2;
                        end else begin
                            data_q <= SOH;
                            end_q  <= 1'b1;
                            ck_idx <= 2'd0;
                            state  <= ST_CK_SOH;
                        end
                    end
                end

                ST_CK_SOH: begin
                    if (byte_hs) begin
                        data_q   <= 8'h00;
                        valid_q  <= 1'b0;
                        end_q    <= 1'b0;
                        ready_q  <= 1'b1;
                        msg_open <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.field_ready_o   = ready_q;
    assign bus.data_o          = data_q;
    assign bus.data_valid_o    = valid_q;
    assign bus.start_message_o = start_q;
    assign bus.end_message_o   = end_q;
    assign dbg_state           = state;

endmodule
